// File: rtl/pixie_pkg.sv
// Shared constants, CPU state codes and sequencer state type for the
// CDP1861 (Pixie) DMA front end.
package pixie_pkg;

    localparam int MCYC_PER_LINE   = 14;
    localparam int LINES_PER_FRAME = 262;
    localparam int FIRST_ACTIVE    = 64;
    localparam int ACTIVE_LINES    = 128;
    localparam int INT_LINE        = 62;
    localparam int DMA_START_MC    = 2;
    localparam int BYTES_PER_LINE  = 8;
    localparam int EF_LEAD         = 4;

    localparam int MC_W   = 4;
    localparam int LINE_W = 9;
    localparam int IDX_W  = 3;

    localparam logic [1:0] SC_FETCH = 2'b00;
    localparam logic [1:0] SC_EXEC  = 2'b01;
    localparam logic [1:0] SC_DMA   = 2'b10;
    localparam logic [1:0] SC_INT   = 2'b11;

    typedef enum logic [1:0] {
        OFF,
        BLANK,
        DMA,
        HAND
    } seq_state_t;

endpackage

// File: rtl/pixie_dma_sequencer_if.sv
// CPU bus, display strobes and line-handoff signals of the Pixie sequencer.
interface pixie_dma_sequencer_if;

    logic        clk_enable;
    logic [1:0]  SC;
    logic        disp_on;
    logic        disp_off;
    logic [7:0]  data_in;
    logic        DMAO;
    logic        INT;
    logic        EFx;
    logic [63:0] line_data;
    logic [6:0]  line_num;
    logic        line_valid;
    logic        line_ack;
    logic        frame_start;
    logic        dma_underrun;

    modport master (
        input  clk_enable, SC, disp_on, disp_off, data_in, line_ack,
        output DMAO, INT, EFx, line_data, line_num, line_valid,
               frame_start, dma_underrun
    );

    modport slave (
        output clk_enable, SC, disp_on, disp_off, data_in, line_ack,
        input  DMAO, INT, EFx, line_data, line_num, line_valid,
               frame_start, dma_underrun
    );

endinterface

// File: rtl/pixie_timing_counter.sv
// Machine-cycle and scan-line counters with the line-position decodes used
// by the sequencer; the decodes describe the machine cycle now executing.
module pixie_timing_counter
    import pixie_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,
    output logic [MC_W-1:0]   mc,
    output logic [LINE_W-1:0] line,
    output logic              mc_wrap,
    output logic              active,
    output logic              int_line,
    output logic              first_line,
    output logic              efx_window,
    output logic              frame_start
);

    always_ff @(posedge clk) begin
        if (reset) begin
            mc   <= '0;
            line <= '0;
        end else if (clk_enable) begin
            if (mc_wrap) begin
                mc   <= '0;
                line <= (line == LINE_W'(LINES_PER_FRAME - 1)) ? '0 : line + 1'b1;
            end else begin
                mc <= mc + 1'b1;
            end
        end
    end

    assign mc_wrap     = (mc == MC_W'(MCYC_PER_LINE - 1));
    assign active      = (line >= LINE_W'(FIRST_ACTIVE)) &&
                         (line <  LINE_W'(FIRST_ACTIVE + ACTIVE_LINES));
    assign int_line    = (line == LINE_W'(INT_LINE));
    assign first_line  = (line == LINE_W'(FIRST_ACTIVE));
    // Two EF windows: the lead-in to the picture and the last lines of it.
    assign efx_window  = ((line >= LINE_W'(FIRST_ACTIVE - EF_LEAD)) &&
                          (line <  LINE_W'(FIRST_ACTIVE))) ||
                         ((line >= LINE_W'(FIRST_ACTIVE + ACTIVE_LINES - EF_LEAD)) &&
                          (line <  LINE_W'(FIRST_ACTIVE + ACTIVE_LINES)));
    assign frame_start = (line == '0) && (mc == '0);

endmodule

// File: rtl/pixie_dma_sequencer.sv
// Pixie display front end: requests 8 DMA bytes per active line, hands each
// captured line to the pixel shifter and drives INT/EFx for the CPU.
module pixie_dma_sequencer
    import pixie_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    pixie_dma_sequencer_if.master bus
);

    logic [MC_W-1:0]   mc;
    logic [LINE_W-1:0] line;
    logic              mc_wrap;
    logic              active;
    logic              int_line;
    logic              first_line;
    logic              efx_window;
    logic              frame_start;

    logic                           en_flag;
    seq_state_t                     state;
    logic [IDX_W-1:0]               idx;
    logic [BYTES_PER_LINE-1:0][7:0] line_buf;
    logic [6:0]                     cur_line;

    pixie_timing_counter u_timing (
        .clk         (clk),
        .reset       (reset),
        .clk_enable  (bus.clk_enable),
        .mc          (mc),
        .line        (line),
        .mc_wrap     (mc_wrap),
        .active      (active),
        .int_line    (int_line),
        .first_line  (first_line),
        .efx_window  (efx_window),
        .frame_start (frame_start)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            en_flag          <= 1'b0;
            state            <= OFF;
            idx              <= '0;
            line_buf         <= '0;
            cur_line         <= '0;
            bus.DMAO         <= 1'b1;
            bus.INT          <= 1'b0;
            bus.EFx          <= 1'b1;
            bus.line_data    <= '0;
            bus.line_num     <= '0;
            bus.line_valid   <= 1'b0;
            bus.frame_start  <= 1'b0;
            bus.dma_underrun <= 1'b0;
        end else begin
            bus.frame_start <= 1'b0;
            // The shifter may take the line on any clk, not just machine cycles.
            if (bus.line_ack) begin
                bus.line_valid <= 1'b0;
            end

            if (bus.clk_enable) begin
                bus.frame_start <= frame_start;
                bus.EFx         <= ~efx_window;

                if (bus.disp_off) begin
                    en_flag <= 1'b0;
                end else if (bus.disp_on) begin
                    en_flag <= 1'b1;
                end

                if (!en_flag || state == OFF) begin
                    bus.INT <= 1'b0;
                end else if (int_line && mc == '0) begin
                    bus.INT <= 1'b1;
                end else if (bus.SC == SC_INT || (first_line && mc == '0)) begin
                    bus.INT <= 1'b0;
                end

                if (!en_flag) begin
                    state    <= OFF;
                    bus.DMAO <= 1'b1;
                end else begin
                    case (state)
                        OFF: state <= BLANK;

                        // Clearing the buffer here makes a short line pad with zeros.
                        BLANK: if (active && mc == MC_W'(DMA_START_MC)) begin
                            bus.DMAO <= 1'b0;
                            state    <= DMA;
                            idx      <= '0;
                            line_buf <= '0;
                            cur_line <= 7'(line - LINE_W'(FIRST_ACTIVE));
                        end

                        DMA: begin
                            if (bus.SC == SC_DMA) begin
                                line_buf[IDX_W'(BYTES_PER_LINE - 1) - idx] <= bus.data_in;
                                idx <= idx + 1'b1;
                            end
                            if (bus.SC == SC_DMA && idx == IDX_W'(BYTES_PER_LINE - 1)) begin
                                bus.DMAO <= 1'b1;
                                state    <= HAND;
                            end else if (mc_wrap) begin
                                bus.dma_underrun <= 1'b1;
                                bus.DMAO         <= 1'b1;
                                state            <= HAND;
                            end
                        end

                        HAND: begin
                            if (!bus.line_valid) begin
                                bus.line_data  <= line_buf;
                                bus.line_num   <= cur_line;
                                bus.line_valid <= 1'b1;
                            end else begin
                                bus.dma_underrun <= 1'b1;
                            end
                            idx   <= '0;
                            state <= BLANK;
                        end

                        default: state <= OFF;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_pixie_dma_sequencer.sv
// Directed bench for pixie_dma_sequencer: a table of machine-cycle vectors
// plus hand-written reset, INT-acknowledge and shifter-stall sequences.
module tb_pixie_dma_sequencer;
    import pixie_pkg::*;

    logic clk;
    logic reset;

    pixie_dma_sequencer_if bus ();

    pixie_dma_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp packs {DMAO, INT, EFx, line_valid, dma_underrun, frame_start}.
    typedef struct packed {
        int          line;
        int          mc;
        logic [1:0]  sc;
        logic        on;
        logic        off;
        logic [7:0]  data;
        logic        ack;
        logic        gap_auto;
        logic [5:0]  exp;
        logic        chk_data;
        logic [63:0] exp_data;
        logic [6:0]  exp_num;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   tb_line = 0;
    int   tb_mc = 0;

    task automatic add_vec(input int l, input int m, input logic [1:0] sc,
                           input logic on, input logic off, input logic [7:0] data,
                           input logic ack, input logic gap_auto, input logic [5:0] exp,
                           input logic chk, input logic [63:0] edata, input logic [6:0] enum_);
        vec_t v;
        v.line = l; v.mc = m; v.sc = sc; v.on = on; v.off = off; v.data = data;
        v.ack = ack; v.gap_auto = gap_auto; v.exp = exp; v.chk_data = chk;
        v.exp_data = edata; v.exp_num = enum_;
        vecs.push_back(v);
    endtask

    task automatic check_flag(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b (next line %0d mc %0d)",
                     name, actual, expected, tb_line, tb_mc);
        end
    endtask

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (next line %0d mc %0d)",
                     name, actual, expected, tb_line, tb_mc);
        end
    endtask

    // One machine cycle: clk_enable high for one clk, outputs sampled on the
    // following falling edge with clk_enable already low again.
    task automatic apply_stimulus(input logic [1:0] sc, input logic on, input logic off,
                                  input logic [7:0] data, input logic ack);
        @(negedge clk);
        bus.clk_enable = 1'b1;
        bus.SC         = sc;
        bus.disp_on    = on;
        bus.disp_off   = off;
        bus.data_in    = data;
        bus.line_ack   = ack;
        @(negedge clk);
        bus.clk_enable = 1'b0;
        bus.SC         = SC_FETCH;
        bus.disp_on    = 1'b0;
        bus.disp_off   = 1'b0;
        bus.data_in    = 8'h00;
        bus.line_ack   = 1'b0;
        if (tb_mc == MCYC_PER_LINE - 1) begin
            tb_mc   = 0;
            tb_line = (tb_line == LINES_PER_FRAME - 1) ? 0 : tb_line + 1;
        end else begin
            tb_mc++;
        end
    endtask

    // Well-behaved CPU/shifter: answers DMA requests with the line number as
    // data and optionally takes every handed-off line at once.
    task automatic idle_cycle(input bit do_dma, input bit do_ack);
        logic [1:0] sc;
        sc = (do_dma && bus.DMAO == 1'b0) ? SC_DMA : SC_FETCH;
        apply_stimulus(sc, 1'b0, 1'b0, 8'(tb_line), do_ack && bus.line_valid);
    endtask

    task automatic run_to(input int l, input int m, input bit do_dma, input bit do_ack);
        int guard = 0;
        while (!(tb_line == l && tb_mc == m) && guard < 5000) begin
            idle_cycle(do_dma, do_ack);
            guard++;
        end
        if (!(tb_line == l && tb_mc == m)) begin
            checks++;
            errors++;
            $display("[TB] FAIL run_to: got line %0d mc %0d expected line %0d mc %0d",
                     tb_line, tb_mc, l, m);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_flag({tag, "_dmao"}, bus.DMAO, 1'b1);
        check_flag({tag, "_int"}, bus.INT, 1'b0);
        check_flag({tag, "_efx"}, bus.EFx, 1'b1);
        check_flag({tag, "_valid"}, bus.line_valid, 1'b0);
        check_flag({tag, "_fs"}, bus.frame_start, 1'b0);
        check_flag({tag, "_under"}, bus.dma_underrun, 1'b0);
        check_output({tag, "_data"}, bus.line_data, 64'h0);
        check_output({tag, "_num"}, 64'(bus.line_num), 64'h0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // line mc  sc  on off data ack gap  {dmao,int,efx,valid,under,fs} chk data num
        add_vec(  0,  0, SC_FETCH, 1, 0, 8'h00, 0, 0, 6'b101001, 0, 64'h0, 7'd0);
        add_vec(  0,  1, SC_FETCH, 0, 0, 8'h00, 0, 0, 6'b101000, 0, 64'h0, 7'd0);
        add_vec( 59, 13, SC_FETCH, 0, 0, 8'h00, 0, 1, 6'b101000, 0, 64'h0, 7'd0);
        add_vec( 60,  0, SC_FETCH, 0, 0, 8'h00, 0, 0, 6'b100000, 0, 64'h0, 7'd0);
        add_vec( 61, 13, SC_FETCH, 0, 0, 8'h00, 0, 1, 6'b100000, 0, 64'h0, 7'd0);
        add_vec( 62,  0, SC_FETCH, 0, 0, 8'h00, 0, 0, 6'b110000, 0, 64'h0, 7'd0);
        add_vec( 63, 13, SC_FETCH, 0, 0, 8'h00, 0, 1, 6'b110000, 0, 64'h0, 7'd0);
        add_vec( 64,  0, SC_FETCH, 0, 0, 8'h00, 0, 0, 6'b101000, 0, 64'h0, 7'd0);
        add_vec( 64,  1, SC_FETCH, 0, 0, 8'h00, 0, 0, 6'b101000, 0, 64'h0, 7'd0);
        add_vec( 64,  2, SC_FETCH, 0, 0, 8'h00, 0, 0, 6'b001000, 0, 64'h0, 7'd0);
        for (int b = 1; b <= 7; b++)
            add_vec(64, 2 + b, SC_DMA, 0, 0, 8'(b), 0, 0, 6'b001000, 0, 64'h0, 7'd0);
        add_vec( 64, 10, SC_DMA,   0, 0, 8'h08, 0, 0, 6'b101000, 0, 64'h0, 7'd0);
        add_vec( 64, 11, SC_FETCH, 0, 0, 8'h00, 0, 0, 6'b101100, 1, 64'h0102030405060708, 7'd0);
        add_vec( 64, 12, SC_FETCH, 0, 0, 8'h00, 1, 0, 6'b101000, 0, 64'h0, 7'd0);
        add_vec( 70,  2, SC_FETCH, 0, 0, 8'h00, 0, 1, 6'b001000, 0, 64'h0, 7'd0);
        for (int b = 1; b <= 5; b++)
            add_vec(70, 2 + b, SC_DMA, 0, 0, 8'(8'hA0 + b), 0, 0, 6'b001000, 0, 64'h0, 7'd0);
        add_vec( 70,  8, SC_FETCH, 0, 0, 8'h00, 0, 0, 6'b001000, 0, 64'h0, 7'd0);
        add_vec( 70, 13, SC_FETCH, 0, 0, 8'h00, 0, 0, 6'b101010, 0, 64'h0, 7'd0);
        add_vec( 71,  0, SC_FETCH, 0, 0, 8'h00, 0, 0, 6'b101110, 1, 64'hA1A2A3A4A5000000, 7'd6);
        add_vec(100,  2, SC_FETCH, 0, 0, 8'h00, 0, 1, 6'b001010, 0, 64'h0, 7'd0);
        add_vec(100,  3, SC_DMA,   0, 1, 8'h11, 0, 0, 6'b001010, 0, 64'h0, 7'd0);
        add_vec(100,  4, SC_DMA,   0, 0, 8'h12, 0, 0, 6'b101010, 0, 64'h0, 7'd0);
        add_vec(101,  0, SC_FETCH, 0, 0, 8'h00, 0, 1, 6'b101010, 0, 64'h0, 7'd0);
        add_vec(101,  3, SC_FETCH, 0, 0, 8'h00, 0, 1, 6'b101010, 0, 64'h0, 7'd0);
        add_vec(103,  0, SC_FETCH, 1, 1, 8'h00, 0, 1, 6'b101010, 0, 64'h0, 7'd0);
        add_vec(104,  3, SC_FETCH, 0, 0, 8'h00, 0, 1, 6'b101010, 0, 64'h0, 7'd0);
        add_vec(104, 11, SC_FETCH, 0, 0, 8'h00, 0, 1, 6'b101010, 0, 64'h0, 7'd0);
        add_vec(188,  0, SC_FETCH, 0, 0, 8'h00, 0, 0, 6'b100010, 0, 64'h0, 7'd0);
        add_vec(191, 13, SC_FETCH, 0, 0, 8'h00, 0, 0, 6'b100010, 0, 64'h0, 7'd0);
        add_vec(192,  0, SC_FETCH, 0, 0, 8'h00, 0, 0, 6'b101010, 0, 64'h0, 7'd0);
        add_vec(261, 13, SC_FETCH, 0, 0, 8'h00, 0, 0, 6'b101010, 0, 64'h0, 7'd0);
        add_vec(  0,  0, SC_FETCH, 0, 0, 8'h00, 0, 0, 6'b101011, 0, 64'h0, 7'd0);

        reset          = 1'b1;
        bus.clk_enable = 1'b0;
        bus.SC         = SC_FETCH;
        bus.disp_on    = 1'b0;
        bus.disp_off   = 1'b0;
        bus.data_in    = 8'h00;
        bus.line_ack   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_state("init");

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            run_to(v.line, v.mc, v.gap_auto, v.gap_auto);
            apply_stimulus(v.sc, v.on, v.off, v.data, v.ack);
            check_flag($sformatf("row%0d_dmao", i), bus.DMAO, v.exp[5]);
            check_flag($sformatf("row%0d_int", i), bus.INT, v.exp[4]);
            check_flag($sformatf("row%0d_efx", i), bus.EFx, v.exp[3]);
            check_flag($sformatf("row%0d_valid", i), bus.line_valid, v.exp[2]);
            check_flag($sformatf("row%0d_under", i), bus.dma_underrun, v.exp[1]);
            check_flag($sformatf("row%0d_fs", i), bus.frame_start, v.exp[0]);
            if (v.chk_data) begin
                check_output($sformatf("row%0d_data", i), bus.line_data, v.exp_data);
                check_output($sformatf("row%0d_num", i), 64'(bus.line_num), 64'(v.exp_num));
            end
        end

        // Reset in the middle of a frame returns everything, counters included.
        run_to(30, 5, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        tb_line = 0;
        tb_mc   = 0;
        check_reset_state("midreset");
        apply_stimulus(SC_FETCH, 1'b1, 1'b0, 8'h00, 1'b0);
        check_flag("midreset_fs", bus.frame_start, 1'b1);

        // INT acknowledged by the CPU before the first active line.
        run_to(62, 0, 1'b1, 1'b0);
        apply_stimulus(SC_FETCH, 1'b0, 1'b0, 8'h00, 1'b0);
        check_flag("intack_set", bus.INT, 1'b1);
        run_to(62, 5, 1'b1, 1'b0);
        apply_stimulus(SC_INT, 1'b0, 1'b0, 8'h00, 1'b0);
        check_flag("intack_clr", bus.INT, 1'b0);
        apply_stimulus(SC_FETCH, 1'b0, 1'b0, 8'h00, 1'b0);
        check_flag("intack_stay", bus.INT, 1'b0);

        // Shifter stalled: the line after an untaken one is dropped.
        run_to(64, 11, 1'b1, 1'b0);
        apply_stimulus(SC_FETCH, 1'b0, 1'b0, 8'h00, 1'b0);
        check_flag("stall_first_valid", bus.line_valid, 1'b1);
        check_flag("stall_first_under", bus.dma_underrun, 1'b0);
        check_output("stall_first_data", bus.line_data, {8{8'h40}});
        run_to(65, 11, 1'b1, 1'b0);
        apply_stimulus(SC_FETCH, 1'b0, 1'b0, 8'h00, 1'b0);
        check_flag("stall_drop_valid", bus.line_valid, 1'b1);
        check_flag("stall_drop_under", bus.dma_underrun, 1'b1);
        check_output("stall_drop_num", 64'(bus.line_num), 64'h0);
        check_output("stall_drop_data", bus.line_data, {8{8'h40}});

        // line_ack acts on a clk with no machine-cycle strobe.
        @(negedge clk);
        bus.line_ack = 1'b1;
        @(negedge clk);
        bus.line_ack = 1'b0;
        check_flag("ack_immediate", bus.line_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixie_dma_sequencer.md
Name: pixie_dma_sequencer

Overview:
- Frontend scheduler for the CDP1861 (Pixie) display path, in the 1802 machine-cycle domain.
- Owns frame/line timing and raises DMA-out requests on active lines. Counts CPU-acknowledged DMA cycles (SC=2'b10) and captures each line's 8 bytes into a line buffer.
- Hands completed lines to the pixel shifter through a valid/ack handshake. Also generates INT and EFx for the CPU.

Parameters:
- MCYC_PER_LINE, 14, machine cycles per scan line
- LINES_PER_FRAME, 262, lines per frame (NTSC)
- FIRST_ACTIVE, 64, first displayed line
- ACTIVE_LINES, 128, displayed lines per frame
- INT_LINE, 62, line on which INT is raised
- DMA_START_MC, 2, machine cycle in the line at which DMAO asserts
- BYTES_PER_LINE, 8, DMA bytes per active line
- EF_LEAD, 4, number of EFx-low lines before the first active line and before the last active line is finished

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- clk_enable  in  1  one-clk strobe per 1802 machine cycle
- SC  in  2  CPU state code (00 fetch, 01 execute, 10 DMA, 11 interrupt)
- disp_on  in  1  display-enable I/O strobe
- disp_off  in  1  display-disable I/O strobe
- data_in  in  8  CPU data bus during DMA cycles
- DMAO  out  1  DMA-out request, active low
- INT  out  1  interrupt request, active high
- EFx  out  1  frame flag, active low
- line_data  out  64  captured line, byte 0 in [63:56]
- line_num  out  7  active line index 0..127
- line_valid  out  1  line_data holds an untaken line
- line_ack  in  1  shifter consumed the line
- frame_start  out  1  one-clk pulse at line 0, mcycle 0
- dma_underrun  out  1  sticky: line ended with fewer than 8 DMA cycles

Behaviour:
- Reset values:
  - DMAO=1, INT=0, EFx=1.
  - line_valid=0, line_data=0, line_num=0, frame_start=0, dma_underrun=0.
  - Counters mc=0, line=0. State OFF. Enable flag cleared.
- Timing: all state advances only on clk_enable. mc counts 0..MCYC_PER_LINE-1. line increments when mc wraps and wraps at LINES_PER_FRAME-1 -> 0. Counters run in every state, including OFF.
- Enable flag: disp_on sets it, disp_off clears it. If both are present in the same clk_enable cycle, disp_off wins.
- FSM states:
  - OFF: DMAO=1, INT=0. Goes to BLANK when the enable flag is set.
  - BLANK: waits. At mc==DMA_START_MC on an active line (FIRST_ACTIVE <= line < FIRST_ACTIVE+ACTIVE_LINES), DMAO=0 and go to DMA.
  - DMA:
    - Each clk_enable with SC==2'b10 writes data_in to buf[idx] and increments idx.
    - When idx reaches 8, DMAO=1 and go to HAND.
    - If mc wraps first, set dma_underrun, pad the missing bytes with 0, DMAO=1, and go to HAND.
  - HAND:
    - If line_valid==0, load line_data from buf and line_num from line-FIRST_ACTIVE, set line_valid=1, clear idx, and go to BLANK.
    - If line_valid==1 (shifter stalled), the new line is dropped, dma_underrun is set, and the state goes to BLANK.
- line_valid clears on the clk edge where line_ack=1. line_ack takes effect immediately and does not wait for clk_enable.
- Disable mid-operation: the FSM moves to OFF at the next clk_enable and DMAO deasserts that same cycle. A partial buffer is discarded. A pending line_valid is kept until acked.
- INT:
  - Set at mc==0 of INT_LINE when enabled.
  - Cleared on a clk_enable with SC==2'b11, or at mc==0 of line FIRST_ACTIVE, whichever comes first.
  - Forced to 0 in OFF.
- EFx: 0 for lines FIRST_ACTIVE-EF_LEAD .. FIRST_ACTIVE-1 and for lines FIRST_ACTIVE+ACTIVE_LINES-EF_LEAD .. FIRST_ACTIVE+ACTIVE_LINES-1, otherwise 1. EFx is independent of the enable flag.
- frame_start: pulses on the clk_enable cycle where line==0 and mc==0.
- Outputs are registered, with a latency of one clk after the qualifying clk_enable.

Decomposition:
- Shared package pixie_pkg holds:
  - SC encodings (SC_FETCH, SC_EXEC, SC_DMA, SC_INT)
  - the timing constants above
  - the FSM state enum {OFF, BLANK, DMA, HAND}
- One sub-module, pixie_timing_counter, holds the mc/line counters and decodes active, int_line, efx_window and frame_start.
- pixie_dma_sequencer holds the FSM, the line buffer and the handshake.

Test Plan:
- Reset mid-frame -> all outputs at their reset values and mc=line=0 the next clk.
- disp_on, then SC=10 on 8 clk_enables per active line with data 0x01..0x08:
  - DMAO low from mc 2 of line 64 until the 8th DMA cycle.
  - line_data=0x0102030405060708, line_num=0, line_valid=1.
- Enabled run with no SC=11:
  - INT rises at line 62 mc 0 and falls at line 64 mc 0.
  - Repeat with SC=11 on line 62 mc 5 -> INT falls the next clk.
- Only 5 DMA cycles given on line 70 -> dma_underrun=1, line_data low 24 bits = 0, line_num=6.
- Hold line_ack=0 across two active lines -> second line dropped, dma_underrun=1, line_num stays at the first line.
- disp_off during DMA on line 100 -> DMAO=1 the next clk_enable, state OFF, no new line_valid. disp_on and disp_off in the same cycle -> stays disabled.
